// File: rtl/pcie_link_monitor.sv
// PCIe link monitor: LTSSM-driven link FSM, saturating link statistics, width/speed decode and LEDs.
// Optional 8-entry LTSSM history buffer enabled by defining LINKMON_HISTORY_EN.
module pcie_link_monitor #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMER_W   = 24,
  parameter int unsigned BLINK_BIT = 24
) (
  input  logic               pld_clk_clk,
  input  logic               any_rstn,
  input  logic [4:0]         ltssm,
  input  logic [52:0]        cfg_sts,
  input  logic               dlup_exit,
  input  logic               hotrst_exit,
  input  logic               stats_clr,
`ifdef LINKMON_HISTORY_EN
  input  logic [2:0]         hist_idx,
  output logic [7:0]         hist_data,
  output logic [3:0]         hist_cnt,
`endif
  output logic               link_up,
  output logic [3:0]         link_width,
  output logic               gen2,
  output logic [CNT_W-1:0]   linkup_cnt,
  output logic [CNT_W-1:0]   recov_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [TIMER_W-1:0] train_time,
  output logic               alive_led,
  output logic               L0_led,
  output logic               comp_led,
  output logic               gen2_led,
  output logic [3:0]         lane_led
);

  localparam int unsigned BLINK_W = BLINK_BIT + 1;

  typedef enum logic [1:0] {ST_DOWN, ST_TRAIN, ST_UP, ST_RECOV} state_t;

  state_t               state, state_nxt;
  logic [4:0]           ltssm_q;
  logic [1:0]           speed_q;
  logic [3:0]           lanes_q;
  logic                 dlup_q, hotrst_q;
  logic [TIMER_W-1:0]   timer;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 is_det, is_comp, is_l0, is_rec, exit_evt;
  logic                 up_entry, width_load, recov_evt, drop_evt, train_entry;
  logic [3:0]           width_dec, width_nxt;
  logic                 unused_cfg;

  assign unused_cfg = ^{cfg_sts[52:39], cfg_sts[34:33], cfg_sts[30:0]};

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TIMER_W-1:0] tmr_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + TIMER_W'(1);
  endfunction

  // Input register stage; exit pulses idle high.
  always_ff @(posedge pld_clk_clk or negedge any_rstn) begin
    if (!any_rstn) begin
      ltssm_q  <= '0;
      speed_q  <= '0;
      lanes_q  <= '0;
      dlup_q   <= 1'b1;
      hotrst_q <= 1'b1;
    end else begin
      ltssm_q  <= ltssm;
      speed_q  <= cfg_sts[32:31];
      lanes_q  <= cfg_sts[38:35];
      dlup_q   <= dlup_exit;
      hotrst_q <= hotrst_exit;
    end
  end

  always_comb begin
    is_det    = (ltssm_q == 5'h00) || (ltssm_q == 5'h01);
    is_comp   = (ltssm_q == 5'h03);
    is_l0     = (ltssm_q == 5'h0F);
    is_rec    = (ltssm_q == 5'h0C) || (ltssm_q == 5'h0D) || (ltssm_q == 5'h0E);
    exit_evt  = !dlup_q || !hotrst_q;
    width_dec = lanes_q[0] ? 4'b0001 :
                lanes_q[1] ? 4'b0010 :
                lanes_q[2] ? 4'b0100 :
                lanes_q[3] ? 4'b1000 : 4'b0000;
  end

  always_ff @(posedge pld_clk_clk or negedge any_rstn) begin
    if (!any_rstn) state <= ST_DOWN;
    else           state <= state_nxt;
  end

  // Exit pulses only matter once the link is up and override the LTSSM code.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_DOWN:  if (is_l0) state_nxt = ST_UP;
                else if (!is_det) state_nxt = ST_TRAIN;
      ST_TRAIN: if (is_l0) state_nxt = ST_UP;
                else if (is_det) state_nxt = ST_DOWN;
      ST_UP:    if (exit_evt || is_det) state_nxt = ST_DOWN;
                else if (is_rec) state_nxt = ST_RECOV;
      ST_RECOV: if (exit_evt || is_det) state_nxt = ST_DOWN;
                else if (is_l0) state_nxt = ST_UP;
                else if (!is_rec) state_nxt = ST_TRAIN;
      default:  state_nxt = ST_DOWN;
    endcase
  end

  always_comb begin
    up_entry    = (state_nxt == ST_UP) && ((state == ST_DOWN) || (state == ST_TRAIN));
    width_load  = (state_nxt == ST_UP) && (state != ST_UP);
    recov_evt   = (state == ST_UP) && (state_nxt == ST_RECOV);
    drop_evt    = (((state == ST_UP) || (state == ST_RECOV)) && (state_nxt == ST_DOWN)) || exit_evt;
    train_entry = (state != ST_TRAIN) && (state_nxt == ST_TRAIN);
    width_nxt   = width_load ? width_dec : link_width;
  end

  // Statistics: clear wins over any coincident increment or latch.
  always_ff @(posedge pld_clk_clk or negedge any_rstn) begin
    if (!any_rstn) begin
      linkup_cnt <= '0;
      recov_cnt  <= '0;
      drop_cnt   <= '0;
      timer      <= '0;
      train_time <= '0;
    end else if (stats_clr) begin
      linkup_cnt <= '0;
      recov_cnt  <= '0;
      drop_cnt   <= '0;
      timer      <= '0;
      train_time <= '0;
    end else begin
      if (up_entry)  linkup_cnt <= cnt_inc(linkup_cnt);
      if (recov_evt) recov_cnt  <= cnt_inc(recov_cnt);
      if (drop_evt)  drop_cnt   <= cnt_inc(drop_cnt);
      if (train_entry)            timer <= '0;
      else if (state == ST_TRAIN) timer <= tmr_inc(timer);
      if (up_entry) train_time <= (state == ST_TRAIN) ? tmr_inc(timer) : '0;
    end
  end

  // Status and active-low LED drives, aligned with the FSM state register.
  always_ff @(posedge pld_clk_clk or negedge any_rstn) begin
    if (!any_rstn) begin
      blink_cnt  <= '0;
      link_up    <= 1'b0;
      link_width <= '0;
      gen2       <= 1'b0;
      alive_led  <= 1'b0;
      L0_led     <= 1'b1;
      comp_led   <= 1'b1;
      gen2_led   <= 1'b1;
      lane_led   <= 4'hF;
    end else begin
      blink_cnt  <= blink_cnt + BLINK_W'(1);
      link_up    <= (state_nxt == ST_UP);
      link_width <= width_nxt;
      gen2       <= (speed_q == 2'b10);
      alive_led  <= blink_cnt[BLINK_BIT];
      L0_led     <= (state_nxt != ST_UP);
      comp_led   <= !is_comp;
      gen2_led   <= (speed_q != 2'b10);
      if ((state_nxt == ST_RECOV) && blink_cnt[BLINK_BIT])
        lane_led <= 4'hF;
      else
        lane_led <= ~{width_nxt[3], |width_nxt[3:2], |width_nxt[3:1], |width_nxt};
    end
  end

`ifdef LINKMON_HISTORY_EN
  logic [4:0] ltssm_d;
  logic [2:0] hist_wptr;
  logic [7:0] hist_mem [8];

  // Circular history of registered LTSSM changes tagged with the FSM state.
  always_ff @(posedge pld_clk_clk or negedge any_rstn) begin
    if (!any_rstn) begin
      ltssm_d   <= '0;
      hist_wptr <= '0;
      hist_cnt  <= '0;
      for (int i = 0; i < 8; i++) hist_mem[i] <= '0;
    end else begin
      ltssm_d <= ltssm_q;
      if (stats_clr) begin
        hist_wptr <= '0;
        hist_cnt  <= '0;
      end else if (ltssm_q != ltssm_d) begin
        hist_mem[hist_wptr] <= {ltssm_q, 3'(state)};
        hist_wptr           <= hist_wptr + 3'd1;
        if (hist_cnt != 4'd8) hist_cnt <= hist_cnt + 4'd1;
      end
    end
  end

  assign hist_data = hist_mem[3'(hist_wptr - 3'd1 - hist_idx)];
`endif

endmodule

// File: tb/tb_pcie_link_monitor.sv
// Directed self-checking bench for pcie_link_monitor (small CNT_W/TIMER_W/BLINK_BIT for short runs).
module tb_pcie_link_monitor;

  localparam int unsigned CNT_W     = 2;
  localparam int unsigned TIMER_W   = 8;
  localparam int unsigned BLINK_BIT = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [4:0]         ltssm;
  logic [52:0]        cfg_sts;
  logic               dlup_exit, hotrst_exit, stats_clr;
  logic               link_up, gen2;
  logic [3:0]         link_width, lane_led;
  logic [CNT_W-1:0]   linkup_cnt, recov_cnt, drop_cnt;
  logic [TIMER_W-1:0] train_time;
  logic               alive_led, L0_led, comp_led, gen2_led;
`ifdef LINKMON_HISTORY_EN
  logic [2:0]         hist_idx;
  logic [7:0]         hist_data;
  logic [3:0]         hist_cnt;
`endif

  int  n_pass = 0;
  int  n_total = 0;
  int  edges;
  int  cyc;
  bit  seen;
  logic prev;

  always #5 clk = ~clk;

  // Edges since reset release; models the free-running blink counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  pcie_link_monitor #(.CNT_W(CNT_W), .TIMER_W(TIMER_W), .BLINK_BIT(BLINK_BIT)) dut (
    .pld_clk_clk (clk),
    .any_rstn    (rst_n),
    .ltssm       (ltssm),
    .cfg_sts     (cfg_sts),
    .dlup_exit   (dlup_exit),
    .hotrst_exit (hotrst_exit),
    .stats_clr   (stats_clr),
`ifdef LINKMON_HISTORY_EN
    .hist_idx    (hist_idx),
    .hist_data   (hist_data),
    .hist_cnt    (hist_cnt),
`endif
    .link_up     (link_up),
    .link_width  (link_width),
    .gen2        (gen2),
    .linkup_cnt  (linkup_cnt),
    .recov_cnt   (recov_cnt),
    .drop_cnt    (drop_cnt),
    .train_time  (train_time),
    .alive_led   (alive_led),
    .L0_led      (L0_led),
    .comp_led    (comp_led),
    .gen2_led    (gen2_led),
    .lane_led    (lane_led)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; ltssm = 5'h00; cfg_sts = '0;
    dlup_exit = 1'b1; hotrst_exit = 1'b1; stats_clr = 1'b0;
`ifdef LINKMON_HISTORY_EN
    hist_idx = 3'd0;
`endif
    tick(3);
    check("rst_linkup_cnt", 32'(linkup_cnt), 0);
    check("rst_recov_cnt", 32'(recov_cnt), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_train_time", 32'(train_time), 0);
    check("rst_link_width", 32'(link_width), 0);
    check("rst_link_up", 32'(link_up), 0);
    check("rst_gen2", 32'(gen2), 0);
    check("rst_L0_led", 32'(L0_led), 1);
    check("rst_lane_led", 32'(lane_led), 32'hF);
    check("rst_comp_led", 32'(comp_led), 1);
    check("rst_gen2_led", 32'(gen2_led), 1);
    check("rst_alive_led", 32'(alive_led), 0);
    rst_n = 1'b1;

    // alive_led period, bounded waits
    prev = alive_led; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (alive_led !== prev) seen = 1'b1;
    end
    check("alive_first_toggle", 32'(seen), 1);
    prev = alive_led; seen = 1'b0; cyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      cyc++;
      if (alive_led !== prev) seen = 1'b1;
    end
    check("alive_period", 32'(cyc), 8);
    check("down_lane_led", 32'(lane_led), 32'hF);

    // Training for 100 cycles then L0, x4 gen2
    ltssm = 5'h02;
    tick(100);
    ltssm = 5'h0F; cfg_sts[37] = 1'b1; cfg_sts[32:31] = 2'b10;
    tick(1);
    check("latency_link_up_early", 32'(link_up), 0);
    tick(1);
    check("train_link_up", 32'(link_up), 1);
    check("train_linkup_cnt", 32'(linkup_cnt), 1);
    check("train_time_100", 32'(train_time), 100);
    check("train_width", 32'(link_width), 32'h4);
    check("train_lane_led", 32'(lane_led), 32'h8);
    check("train_gen2", 32'(gen2), 1);
    check("train_gen2_led", 32'(gen2_led), 0);
    check("train_L0_led", 32'(L0_led), 0);

    // Recovery with blinking lane LEDs
    ltssm = 5'h0C;
    tick(2);
    check("recov_cnt_1", 32'(recov_cnt), 1);
    check("recov_link_up", 32'(link_up), 0);
    check("recov_L0_led", 32'(L0_led), 1);
    ltssm = 5'h0D;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      check("recov_lane_blink", 32'(lane_led), (((edges - 1) >> BLINK_BIT) & 1) != 0 ? 32'hF : 32'h8);
      check("recov_alive", 32'(alive_led), 32'(((edges - 1) >> BLINK_BIT) & 1));
    end
    ltssm = 5'h0F;
    tick(2);
    check("reup_link_up", 32'(link_up), 1);
    check("reup_linkup_cnt", 32'(linkup_cnt), 1);
    check("reup_lane_led", 32'(lane_led), 32'h8);

    // dlup_exit coincident with DET counts one drop
    dlup_exit = 1'b0; ltssm = 5'h00;
    tick(1);
    dlup_exit = 1'b1;
    tick(1);
    check("drop_once", 32'(drop_cnt), 1);
    check("drop_link_up", 32'(link_up), 0);
    check("drop_L0_led", 32'(L0_led), 1);
    tick(2);
    check("drop_stable", 32'(drop_cnt), 1);

    // Direct DOWN->UP and counter saturation
    ltssm = 5'h0F;
    tick(2);
    check("direct_train_time", 32'(train_time), 0);
    check("direct_linkup_cnt", 32'(linkup_cnt), 2);
    ltssm = 5'h00;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      ltssm = 5'h0F; tick(2);
      ltssm = 5'h00; tick(2);
    end
    check("sat_linkup_cnt", 32'(linkup_cnt), 3);
    check("sat_drop_cnt", 32'(drop_cnt), 3);
    ltssm = 5'h0F;
    tick(1);
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    check("clr_linkup_cnt", 32'(linkup_cnt), 0);
    check("clr_drop_cnt", 32'(drop_cnt), 0);
    check("clr_recov_cnt", 32'(recov_cnt), 0);
    check("clr_link_up", 32'(link_up), 1);

    // RECOV->UP relatches width with lowest-index priority
    cfg_sts[38:35] = 4'b1010; ltssm = 5'h0E;
    tick(2);
    check("recov2_cnt", 32'(recov_cnt), 1);
    ltssm = 5'h0F;
    tick(2);
    check("prio_width", 32'(link_width), 32'h2);
    check("prio_lane_led", 32'(lane_led), 32'hC);
    check("prio_linkup_cnt", 32'(linkup_cnt), 0);
    ltssm = 5'h03;
    tick(2);
    check("comp_led_on", 32'(comp_led), 0);
    check("comp_link_up", 32'(link_up), 1);
    ltssm = 5'h0F;
    tick(2);
    check("comp_led_off", 32'(comp_led), 1);

    // hotrst_exit from RECOV, then long training saturates the timer
    ltssm = 5'h0D;
    tick(2);
    check("recov3_cnt", 32'(recov_cnt), 2);
    hotrst_exit = 1'b0;
    tick(1);
    hotrst_exit = 1'b1;
    tick(1);
    check("hot_drop_cnt", 32'(drop_cnt), 1);
    check("hot_link_up", 32'(link_up), 0);
    cfg_sts[38:35] = 4'b0000; ltssm = 5'h02;
    tick(300);
    ltssm = 5'h0F;
    tick(2);
    check("tmr_sat", 32'(train_time), 32'hFF);
    check("tmr_linkup_cnt", 32'(linkup_cnt), 1);
    check("none_width", 32'(link_width), 0);
    check("none_lane_led", 32'(lane_led), 32'hF);

    // Reset mid-training aborts the timer
    ltssm = 5'h00;
    tick(2);
    check("pre_rst_drop", 32'(drop_cnt), 2);
    ltssm = 5'h02;
    tick(10);
    rst_n = 1'b0;
    tick(1);
    check("midrst_link_up", 32'(link_up), 0);
    check("midrst_train_time", 32'(train_time), 0);
    check("midrst_linkup_cnt", 32'(linkup_cnt), 0);
    check("midrst_L0_led", 32'(L0_led), 1);
    rst_n = 1'b1;
    tick(5);
    ltssm = 5'h0F;
    tick(2);
    check("postrst_train_time", 32'(train_time), 5);
    check("postrst_linkup_cnt", 32'(linkup_cnt), 1);

`ifdef LINKMON_HISTORY_EN
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    tick(1);
    check("hist_clr", 32'(hist_cnt), 0);
    for (int i = 1; i <= 10; i++) begin
      ltssm = 5'(i);
      tick(2);
    end
    tick(2);
    check("hist_cnt_sat", 32'(hist_cnt), 8);
    hist_idx = 3'd0;
    #1;
    check("hist_newest", 32'(hist_data[7:3]), 32'h0A);
    hist_idx = 3'd7;
    #1;
    check("hist_oldest", 32'(hist_data[7:3]), 32'h03);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
